// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies. The control unit decodes into the same op constants.
package mdu_pkg;

    // MDUOp encodings driven by the control unit
    localparam logic [2:0] MDU_NONE  = 3'b000;
    localparam logic [2:0] MDU_MULT  = 3'b001;
    localparam logic [2:0] MDU_MULTU = 3'b010;
    localparam logic [2:0] MDU_DIV   = 3'b011;
    localparam logic [2:0] MDU_DIVU  = 3'b100;
    localparam logic [2:0] MDU_MTHI  = 3'b101;
    localparam logic [2:0] MDU_MTLO  = 3'b110;

    // Default busy durations, in cycles
    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    // Control FSM states; state_q in mdu is of this type so checkers can bind to it
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_calc.sv
// Combinational arithmetic for the MDU: produces {hi, lo} for the selected
// mult/div op plus a divide-by-zero flag. Includes the INT_MIN / -1 case.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] hilo,
    output logic        div_zero
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               b_zero;
    logic               int_min_ovf;

    // Evaluate every candidate result; the op select below picks one
    always_comb begin
        b_zero      = (b == 32'h0000_0000);
        int_min_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        prod_s      = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prod_u      = {32'h0000_0000, a} * {32'h0000_0000, b};
        quot_s      = '0;
        rem_s       = '0;
        quot_u      = '0;
        rem_u       = '0;
        // Divide by zero yields zeros here; the commit logic skips the write anyway
        if (!b_zero) begin
            quot_u = a / b;
            rem_u  = a % b;
            if (int_min_ovf) begin
                // Quotient overflows back to INT_MIN, remainder is exactly zero
                quot_s = $signed(32'h8000_0000);
                rem_s  = '0;
            end else begin
                // SV signed divide truncates toward zero; remainder follows dividend sign
                quot_s = $signed(a) / $signed(b);
                rem_s  = $signed(a) % $signed(b);
            end
        end
    end

    // Select {hi, lo} and the zero-divisor flag by op
    always_comb begin
        hilo     = '0;
        div_zero = 1'b0;
        case (op)
            MDU_MULT:  hilo = prod_s;
            MDU_MULTU: hilo = prod_u;
            MDU_DIV: begin
                hilo     = {rem_s, quot_s};
                div_zero = b_zero;
            end
            MDU_DIVU: begin
                hilo     = {rem_u, quot_u};
                div_zero = b_zero;
            end
            default: hilo = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit for the E stage. The result is computed when the op is
// accepted and held in pending registers; a down-counter models the latency and
// HI/LO are committed when it expires. Busy is a pure decode of the state flop.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] E_MDU_A,
    input  logic [31:0] E_MDU_B,
    input  logic [2:0]  E_MDU_MDUOp,
    input  logic        E_MDU_Start,
    output logic        E_MDU_Busy,
    output logic [31:0] E_MDU_HI,
    output logic [31:0] E_MDU_LO
);

    // Handshake: Start is a one-cycle qualifier sampled only in IDLE; while
    // Busy is high any Start is dropped, and the pipeline is expected to stall.

    localparam int              CNT_W    = $clog2(DIV_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_hilo_q, pend_hilo_d;
    logic             pend_dz_q, pend_dz_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [63:0]      calc_hilo;
    logic             calc_dz;

    mdu_calc u_calc (
        .op       (E_MDU_MDUOp),
        .a        (E_MDU_A),
        .b        (E_MDU_B),
        .hilo     (calc_hilo),
        .div_zero (calc_dz)
    );

    // Next-state: accept ops in IDLE, count down in RUN, commit on expiry
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hilo_d = pend_hilo_q;
        pend_dz_d   = pend_dz_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (E_MDU_Start) begin
                    case (E_MDU_MDUOp)
                        MDU_MULT, MDU_MULTU: begin
                            pend_hilo_d = calc_hilo;
                            pend_dz_d   = 1'b0;
                            cnt_d       = CNT_MULT;
                            state_d     = ST_RUN;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            pend_hilo_d = calc_hilo;
                            pend_dz_d   = calc_dz;
                            cnt_d       = CNT_DIV;
                            state_d     = ST_RUN;
                        end
                        MDU_MTHI: hi_d = E_MDU_A;
                        MDU_MTLO: lo_d = E_MDU_A;
                        MDU_NONE: hi_d = hi_q;
                        default:  hi_d = hi_q;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    // A zero divisor burns the full latency but leaves HI/LO alone
                    if (!pend_dz_q) begin
                        hi_d = pend_hilo_q[63:32];
                        lo_d = pend_hilo_q[31:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, counter, pending result and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            pend_hilo_q <= '0;
            pend_dz_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hilo_q <= pend_hilo_d;
            pend_dz_q   <= pend_dz_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign E_MDU_Busy = (state_q == ST_RUN);
    assign E_MDU_HI   = hi_q;
    assign E_MDU_LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: expected {hi, lo} pushed when an op is issued,
// popped and compared when Busy falls. Inputs change and outputs are sampled
// on the falling clock edge.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] E_MDU_A;
    logic [31:0] E_MDU_B;
    logic [2:0]  E_MDU_MDUOp;
    logic        E_MDU_Start;
    logic        E_MDU_Busy;
    logic [31:0] E_MDU_HI;
    logic [31:0] E_MDU_LO;

    logic [63:0] exp_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [31:0] cur_hi   = 32'h0;
    logic [31:0] cur_lo   = 32'h0;

    // Clock
    always #5 clk = ~clk;

    mdu dut (
        .clk         (clk),
        .reset       (reset),
        .E_MDU_A     (E_MDU_A),
        .E_MDU_B     (E_MDU_B),
        .E_MDU_MDUOp (E_MDU_MDUOp),
        .E_MDU_Start (E_MDU_Start),
        .E_MDU_Busy  (E_MDU_Busy),
        .E_MDU_HI    (E_MDU_HI),
        .E_MDU_LO    (E_MDU_LO)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one Start pulse from the current falling edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MDU_Start = 1'b1;
        E_MDU_MDUOp = op;
        E_MDU_A     = a;
        E_MDU_B     = b;
        @(negedge clk);
        E_MDU_Start = 1'b0;
        E_MDU_MDUOp = MDU_NONE;
    endtask

    // Count falling edges with Busy high, bounded so a stuck Busy still ends
    task automatic count_busy(input string tag, input int exp_n);
        int n = 0;
        while (E_MDU_Busy === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 32'(n), 32'(exp_n));
    endtask

    // Pop the scoreboard and compare against the committed HI/LO
    task automatic commit_check(input string tag);
        logic [63:0] e;
        check({tag, "_sb_avail"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_hi"}, E_MDU_HI, e[63:32]);
            check({tag, "_lo"}, E_MDU_LO, e[31:0]);
            cur_hi = e[63:32];
            cur_lo = e[31:0];
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cycles,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        exp_q.push_back({exp_hi, exp_lo});
        issue(op, a, b);
        check({tag, "_busy_on"}, 32'(E_MDU_Busy), 32'd1);
        check({tag, "_hi_hold"}, E_MDU_HI, cur_hi);
        check({tag, "_lo_hold"}, E_MDU_LO, cur_lo);
        count_busy(tag, cycles);
        commit_check(tag);
    endtask

    initial begin
        int highs;
        reset       = 1'b0;
        E_MDU_A     = '0;
        E_MDU_B     = '0;
        E_MDU_MDUOp = MDU_NONE;
        E_MDU_Start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(E_MDU_Busy), 32'd0);
        check("rst_hi", E_MDU_HI, 32'h0);
        check("rst_lo", E_MDU_LO, 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Signed and unsigned multiply, then signed divide, back-to-back
        run_op("mult_m1x2",  MDU_MULT,  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu_ffx2", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("div_m7d2",   MDU_DIV,   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // mthi then mtlo on consecutive cycles
        E_MDU_Start = 1'b1;
        E_MDU_MDUOp = MDU_MTHI;
        E_MDU_A     = 32'h1234_5678;
        @(negedge clk);
        check("mthi_hi", E_MDU_HI, 32'h1234_5678);
        check("mthi_lo", E_MDU_LO, cur_lo);
        check("mthi_busy", 32'(E_MDU_Busy), 32'd0);
        E_MDU_MDUOp = MDU_MTLO;
        E_MDU_A     = 32'h9ABC_DEF0;
        @(negedge clk);
        E_MDU_Start = 1'b0;
        E_MDU_MDUOp = MDU_NONE;
        check("mtlo_lo", E_MDU_LO, 32'h9ABC_DEF0);
        check("mtlo_hi", E_MDU_HI, 32'h1234_5678);
        check("mtlo_busy", 32'(E_MDU_Busy), 32'd0);
        cur_hi = 32'h1234_5678;
        cur_lo = 32'h9ABC_DEF0;

        // Divide by zero keeps HI/LO
        run_op("divu_by0", MDU_DIVU, 32'd7, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0);

        // Overflow corner and unsigned divide
        run_op("div_intmin", MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
        run_op("divu_ff10",  MDU_DIVU, 32'hFFFF_FFFF, 32'h10, 10, 32'hF, 32'h0FFF_FFFF);

        // Start re-pulsed during busy cycle 2 must be ignored
        exp_q.push_back({32'h0, 32'd12});
        issue(MDU_MULT, 32'd3, 32'd4);
        check("rep_busy_c1", 32'(E_MDU_Busy), 32'd1);
        @(negedge clk);
        check("rep_busy_c2", 32'(E_MDU_Busy), 32'd1);
        issue(MDU_DIV, 32'd100, 32'd7);
        count_busy("rep_rest", 3);
        commit_check("rep");
        highs = 0;
        repeat (12) begin
            @(negedge clk);
            if (E_MDU_Busy === 1'b1) highs++;
        end
        check("rep_no_second", 32'(highs), 32'd0);
        check("rep_lo_keep", E_MDU_LO, 32'd12);

        // Reset in the middle of a divide
        issue(MDU_MTHI, 32'hCAFE_F00D, 32'd0);
        check("pre_rst_hi", E_MDU_HI, 32'hCAFE_F00D);
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(E_MDU_Busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("async_busy", 32'(E_MDU_Busy), 32'd0);
        check("async_hi", E_MDU_HI, 32'h0);
        check("async_lo", E_MDU_LO, 32'h0);
        @(negedge clk);
        reset  = 1'b1;
        cur_hi = 32'h0;
        cur_lo = 32'h0;
        highs  = 0;
        repeat (15) begin
            @(negedge clk);
            if (E_MDU_Busy === 1'b1) highs++;
        end
        check("post_rst_busy", 32'(highs), 32'd0);
        check("post_rst_hi", E_MDU_HI, cur_hi);
        check("post_rst_lo", E_MDU_LO, cur_lo);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the P6 pipeline, the multi-cycle counterpart to the single-cycle integer ALU. It executes mult, multu, div, divu, mthi and mtlo, and owns the HI/LO architectural registers. While it works it raises a busy flag so the hazard unit can stall mult/div/mfhi/mflo/mthi/mtlo in D. HI and LO are read continuously for mfhi/mflo.

## Interface
Parameters:
- MULT_CYCLES, 5: busy duration of mult/multu.
- DIV_CYCLES, 10: busy duration of div/divu.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- E_MDU_A  input  32  rs operand.
- E_MDU_B  input  32  rt operand.
- E_MDU_MDUOp  input  3  op select: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (no-op).
- E_MDU_Start  input  1  single-cycle qualifier; op and operands are sampled only when high.
- E_MDU_Busy  output  1  high while a mult/div is in flight.
- E_MDU_HI  output  32  current HI register.
- E_MDU_LO  output  32  current LO register.

## Operation
- State machine: IDLE and RUN. A counter of ceil(log2(DIV_CYCLES+1)) bits tracks remaining cycles.
- IDLE, Start=1, op mult/multu/div/divu:
  - Compute the result from the sampled A/B.
  - Latch it into the pending hi/lo registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES and go to RUN.
- IDLE, Start=1, op mthi/mtlo: write A into HI or LO at that edge. Stay in IDLE, Busy stays 0.
- IDLE, Start=1, op none/reserved: no effect.
- RUN: decrement the counter each edge. At the edge where it goes 1→0, commit pending to HI/LO and return to IDLE.
- Start while in RUN: ignored completely. The pipeline never issues this; the bench checks it.
- mult: signed 32×32→64. HI = product[63:32], LO = product[31:0].
- multu: the same, unsigned.
- div: signed. LO = quotient truncated toward zero, HI = remainder with the sign of the dividend.
- div with 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- divu: unsigned quotient and remainder.
- Divide by zero (div or divu): the op still runs the full DIV_CYCLES with Busy high. At commit, HI/LO are left unchanged.
- Reset (asserted at any time, including mid-RUN): HI=0, LO=0, Busy=0, state IDLE, counter 0, pending=0. The in-flight op is discarded.

## Timing
- Start sampled at edge T0 (mult/multu):
  - Busy=1 from just after T0 through edge T0+5.
  - HI/LO updated at edge T0+5, which is also when Busy falls.
  - Results visible in the cycle after T0+5.
- div/divu: the same pattern with T0+10.
- mthi/mtlo: HI/LO updated at edge T0, so one-cycle latency.
- Busy is a registered output with no combinational path from Start. The hazard unit ORs Start itself.
- HI/LO change only at commit edges, mthi/mtlo edges, or reset.
- Back-to-back ops: a Start in the first cycle with Busy=0 after a commit is accepted.

## Structure
- Shared package (mdu_pkg):
  - Op encoding constants (MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO).
  - The state enum.
  - Default MULT_CYCLES/DIV_CYCLES.
  - The control unit imports the same op constants.
- One sub-module: mdu_calc, a combinational block that takes op, A and B and returns a 64-bit {hi, lo} plus a div-by-zero flag. It holds all signed/unsigned arithmetic and the INT_MIN/-1 handling. The top holds the FSM, counter, pending registers and HI/LO.

## Test plan
- Reset then mult with A=0xFFFFFFFF, B=2 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE. Then div A=0xFFFFFFF9 (−7), B=2 → Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 on consecutive cycles → HI and LO updated one edge after each Start, Busy never high. Then divu A=7, B=0 → Busy 10 cycles, HI/LO still 0x12345678/0x9ABCDEF0.
- div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. Then divu 0xFFFFFFFF/0x10 → LO=0x0FFFFFFF, HI=0xF.
- mult 3×4 with Start re-pulsed (op div, 100/7) in busy cycle 2 → second op ignored, Busy falls after 5 cycles, HI=0, LO=12.
- div started, reset asserted in busy cycle 4 → Busy, HI and LO go to 0 immediately (asynchronous). After release there is no late commit and Busy stays 0.
